// File: rtl/uart_transceiver_if.sv
// Bus-side bundle for uart_transceiver: TX byte handshake, RX frame report and the two serial lines.
// The slave modport is the UART itself; master is whoever feeds it and drives the rx line.
interface uart_transceiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport slave (
        input  tx_data, tx_valid, rx,
        output tx_ready, tx_busy, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport master (
        output tx_data, tx_valid, rx,
        input  tx_ready, tx_busy, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex UART: independent TX and RX engines sharing only clk/rst.
// Fixed clocks-per-bit divider, optional even/odd parity, 1 or 2 stop bits.
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input logic               clk,
    input logic               rst,
    uart_transceiver_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY_ODD != 0) ? ~^d : ^d;
    endfunction

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_bit_end;

    rx_state_t            rx_state, rx_state_n;
    logic                 rx_sync_p0, rx_sync_p1;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_bit_end, rx_half, rx_line;

    assign tx_bit_end   = (tx_cnt == BIT_LAST);
    assign bus.tx_ready = (tx_state == TX_IDLE);
    assign bus.tx_busy  = (tx_state != TX_IDLE);

    always_comb begin
        tx_state_n = tx_state;
        bus.tx     = 1'b1;
        case (tx_state)
            TX_IDLE:   if (bus.tx_valid) tx_state_n = TX_START;
            TX_START: begin
                bus.tx = 1'b0;
                if (tx_bit_end) tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                bus.tx = tx_shift[0];
                if (tx_bit_end && tx_bit == DATA_LAST)
                    tx_state_n = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                bus.tx = tx_par;
                if (tx_bit_end) tx_state_n = TX_STOP;
            end
            TX_STOP:   if (tx_bit_end && tx_bit == STOP_LAST) tx_state_n = TX_IDLE;
            default:   tx_state_n = TX_IDLE;
        endcase
    end

    // tx_bit counts data bits in DATA and stop bits in STOP; it restarts on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_state == TX_IDLE || tx_bit_end) tx_cnt <= '0;
            else                                    tx_cnt <= tx_cnt + CW'(1);
            if (tx_state_n != tx_state) tx_bit <= '0;
            else if (tx_bit_end)        tx_bit <= tx_bit + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_state == TX_IDLE && bus.tx_valid) begin
            tx_shift <= bus.tx_data;
            tx_par   <= parity_of(bus.tx_data);
        end else if (tx_state == TX_DATA && tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    assign rx_line    = rx_sync_p1;
    assign rx_bit_end = (rx_cnt == BIT_LAST);
    assign rx_half    = (rx_cnt == HALF_LAST);

    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:   if (!rx_line) rx_state_n = RX_START;
            RX_START:  if (rx_half) rx_state_n = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_bit_end && rx_bit == DATA_LAST)
                    rx_state_n = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_bit_end) rx_state_n = RX_STOP;
            // Leaving at mid stop bit keeps half a bit of margin for the next start edge
            RX_STOP:   if (rx_bit_end) rx_state_n = rx_line ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (rx_line) rx_state_n = RX_IDLE;
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0        <= 1'b1;
            rx_sync_p1        <= 1'b1;
            rx_state          <= RX_IDLE;
            rx_cnt            <= '0;
            rx_bit            <= '0;
            bus.rx_valid      <= 1'b0;
            bus.rx_data       <= '0;
            bus.rx_parity_err <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
        end else begin
            rx_sync_p0   <= bus.rx;
            rx_sync_p1   <= rx_sync_p0;
            rx_state     <= rx_state_n;
            if (rx_state_n != rx_state || rx_bit_end) rx_cnt <= '0;
            else                                      rx_cnt <= rx_cnt + CW'(1);
            if (rx_state_n != rx_state)             rx_bit <= '0;
            else if (rx_state == RX_DATA && rx_bit_end) rx_bit <= rx_bit + BW'(1);
            bus.rx_valid <= (rx_state == RX_STOP) && rx_bit_end;
            if (rx_state == RX_STOP && rx_bit_end) begin
                bus.rx_data       <= rx_shift;
                bus.rx_parity_err <= (PARITY_EN != 0) && (rx_par_bit != parity_of(rx_shift));
                bus.rx_frame_err  <= ~rx_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_bit_end)
            rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
        if (rx_state == RX_PARITY && rx_bit_end)
            rx_par_bit <= rx_line;
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: default, even-parity and odd-parity instances,
// each with a selectable tx->rx loopback or bench-driven rx line.
module tb_uart_transceiver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic lb0, lb1, lb2;
    logic drv0, drv1, drv2;

    uart_transceiver_if #(.DATA_BITS(8)) bus0 ();
    uart_transceiver_if #(.DATA_BITS(8)) bus1 ();
    uart_transceiver_if #(.DATA_BITS(8)) bus2 ();

    assign bus0.rx = lb0 ? bus0.tx : drv0;
    assign bus1.rx = lb1 ? bus1.tx : drv1;
    assign bus2.rx = lb2 ? bus2.tx : drv2;

    uart_transceiver u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    uart_transceiver #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    uart_transceiver #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    int checks;
    int errors;
    int vcnt [3];
    logic [7:0] last_d [3];
    logic [7:0] prev_d [3];
    logic last_pe [3];
    logic last_fe [3];
    logic wave [0:399];
    logic rdy [0:399];

    always @(negedge clk) begin
        if (bus0.rx_valid) begin
            vcnt[0] <= vcnt[0] + 1; prev_d[0] <= last_d[0]; last_d[0] <= bus0.rx_data;
            last_pe[0] <= bus0.rx_parity_err; last_fe[0] <= bus0.rx_frame_err;
        end
        if (bus1.rx_valid) begin
            vcnt[1] <= vcnt[1] + 1; prev_d[1] <= last_d[1]; last_d[1] <= bus1.rx_data;
            last_pe[1] <= bus1.rx_parity_err; last_fe[1] <= bus1.rx_frame_err;
        end
        if (bus2.rx_valid) begin
            vcnt[2] <= vcnt[2] + 1; prev_d[2] <= last_d[2]; last_d[2] <= bus2.rx_data;
            last_pe[2] <= bus2.rx_parity_err; last_fe[2] <= bus2.rx_frame_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int inst, input logic [7:0] d);
        case (inst)
            0: bus0.tx_data = d;
            1: bus1.tx_data = d;
            default: bus2.tx_data = d;
        endcase
    endtask

    task automatic set_valid(input int inst, input logic v);
        case (inst)
            0: bus0.tx_valid = v;
            1: bus1.tx_valid = v;
            default: bus2.tx_valid = v;
        endcase
    endtask

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0: drv0 = v;
            1: drv1 = v;
            default: drv2 = v;
        endcase
    endtask

    function automatic logic get_tx(input int inst);
        case (inst)
            0: return bus0.tx;
            1: return bus1.tx;
            default: return bus2.tx;
        endcase
    endfunction

    function automatic logic get_ready(input int inst);
        case (inst)
            0: return bus0.tx_ready;
            1: return bus1.tx_ready;
            default: return bus2.tx_ready;
        endcase
    endfunction

    // Expected line level for bit slot k of a frame; pm: 0 none, 1 even, 2 odd parity
    function automatic logic frame_bit(input logic [7:0] d, input int k, input int pm);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && pm != 0) return (pm == 2) ? ~^d : ^d;
        return 1'b1;
    endfunction

    function automatic int count_rdy(input int n, input logic v);
        int c = 0;
        for (int i = 0; i < n; i++) if (rdy[i] === v) c++;
        return c;
    endfunction

    task automatic start_tx(input int inst, input logic [7:0] d);
        set_data(inst, d);
        set_valid(inst, 1'b1);
        tick(1);
    endtask

    // Sample index i is taken at the falling edge i+1/2 cycles after the handshake edge
    task automatic capture(input int inst, input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wave[i] = get_tx(inst);
            rdy[i]  = get_ready(inst);
            if (i == drop_at) set_valid(inst, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wave_chk(input string tag, input logic [7:0] d, input int pm, input int off);
        int nb;
        int mism;
        nb = (pm != 0) ? 11 : 10;
        mism = 0;
        for (int i = 0; i < nb * 16; i++)
            if (wave[off + i] !== frame_bit(d, i / 16, pm)) mism++;
        chk(tag, mism, 0);
    endtask

    task automatic drive_bits(input int inst, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            set_line(inst, bits[i]);
            tick(16);
        end
    endtask

    int base;

    initial begin
        rst = 1'b1;
        lb0 = 1'b1; lb1 = 1'b1; lb2 = 1'b1;
        drv0 = 1'b1; drv1 = 1'b1; drv2 = 1'b1;
        bus0.tx_valid = 1'b0; bus1.tx_valid = 1'b0; bus2.tx_valid = 1'b0;
        bus0.tx_data = 8'h00; bus1.tx_data = 8'h00; bus2.tx_data = 8'h00;
        tick(4);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", bus0.tx, 1);
        chk("rst_ready", bus0.tx_ready, 1);
        chk("rst_busy", bus0.tx_busy, 0);
        chk("rst_rx_data", bus0.rx_data, 0);
        chk("rst_rx_valid", bus0.rx_valid, 0);
        chk("rst_perr", bus0.rx_parity_err, 0);
        chk("rst_ferr", bus0.rx_frame_err, 0);
        tick(4);

        // 0xA5 with defaults, looped back
        base = vcnt[0];
        start_tx(0, 8'hA5);
        capture(0, 176, 0);
        tick(4);
        wave_chk("t1_wave", 8'hA5, 0, 0);
        chk("t1_start_first", wave[0], 0);
        chk("t1_start_last", wave[15], 0);
        chk("t1_bit0", wave[24], 1);
        chk("t1_bit1", wave[40], 0);
        chk("t1_bit7", wave[136], 1);
        chk("t1_ready_low", count_rdy(176, 1'b0), 160);
        chk("t1_idle_tx", wave[160], 1);
        chk("t1_idle_ready", rdy[160], 1);
        chk("t1_rx_count", vcnt[0] - base, 1);
        chk("t1_rx_data", last_d[0], 8'hA5);
        chk("t1_rx_perr", last_pe[0], 0);
        chk("t1_rx_ferr", last_fe[0], 0);

        // 0x07 with even and odd parity, looped back
        base = vcnt[1];
        start_tx(1, 8'h07);
        capture(1, 192, 0);
        tick(4);
        wave_chk("t2_even_wave", 8'h07, 1, 0);
        chk("t2_par_even", wave[152], 1);
        chk("t2_even_count", vcnt[1] - base, 1);
        chk("t2_even_data", last_d[1], 8'h07);
        chk("t2_even_perr", last_pe[1], 0);
        base = vcnt[2];
        start_tx(2, 8'h07);
        capture(2, 192, 0);
        tick(4);
        wave_chk("t2_odd_wave", 8'h07, 2, 0);
        chk("t2_par_odd", wave[152], 0);
        chk("t2_odd_count", vcnt[2] - base, 1);
        chk("t2_odd_data", last_d[2], 8'h07);
        chk("t2_odd_perr", last_pe[2], 0);

        // Parity bit flipped on the even-parity receiver
        lb1 = 1'b0;
        base = vcnt[1];
        drive_bits(1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
        tick(24);
        chk("t2_flip_count", vcnt[1] - base, 1);
        chk("t2_flip_data", last_d[1], 8'h07);
        chk("t2_flip_perr", last_pe[1], 1);
        chk("t2_flip_ferr", last_fe[1], 0);

        // Low stop bit followed by three frame times of break
        lb0 = 1'b0;
        base = vcnt[0];
        drive_bits(0, 16'({1'b0, 8'h55, 1'b0}), 10);
        tick(480);
        set_line(0, 1'b1);
        tick(32);
        chk("t3_brk_count", vcnt[0] - base, 1);
        chk("t3_brk_ferr", last_fe[0], 1);
        chk("t3_brk_data", last_d[0], 8'h55);
        drive_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10);
        tick(24);
        chk("t3_next_count", vcnt[0] - base, 2);
        chk("t3_next_data", last_d[0], 8'h3C);
        chk("t3_next_perr", last_pe[0], 0);
        chk("t3_next_ferr", last_fe[0], 0);

        // Five-cycle glitch is rejected
        base = vcnt[0];
        set_line(0, 1'b0);
        tick(5);
        set_line(0, 1'b1);
        tick(40);
        chk("t4_glitch_count", vcnt[0] - base, 0);
        drive_bits(0, 16'({1'b1, 8'h96, 1'b0}), 10);
        tick(24);
        chk("t4_next_count", vcnt[0] - base, 1);
        chk("t4_next_data", last_d[0], 8'h96);
        chk("t4_next_ferr", last_fe[0], 0);

        // Back-to-back frames with tx_valid held high
        lb0 = 1'b1;
        tick(4);
        base = vcnt[0];
        start_tx(0, 8'h00);
        set_data(0, 8'hFF);
        capture(0, 330, 200);
        tick(4);
        wave_chk("t5_wave0", 8'h00, 0, 0);
        chk("t5_gap_tx", wave[160], 1);
        chk("t5_gap_ready", rdy[160], 1);
        chk("t5_second_start", wave[161], 0);
        chk("t5_ready_high", count_rdy(321, 1'b1), 1);
        wave_chk("t5_wave1", 8'hFF, 0, 161);
        chk("t5_rx_count", vcnt[0] - base, 2);
        chk("t5_rx_first", prev_d[0], 8'h00);
        chk("t5_rx_second", last_d[0], 8'hFF);

        // Reset mid-DATA, then a clean frame
        base = vcnt[0];
        start_tx(0, 8'h00);
        set_valid(0, 1'b0);
        tick(60);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_tx_after_rst", bus0.tx, 1);
        chk("t6_ready_after_rst", bus0.tx_ready, 1);
        tick(200);
        chk("t6_no_valid", vcnt[0] - base, 0);
        start_tx(0, 8'h5A);
        capture(0, 176, 0);
        tick(4);
        wave_chk("t6_wave", 8'h5A, 0, 0);
        chk("t6_rx_count", vcnt[0] - base, 1);
        chk("t6_rx_data", last_d[0], 8'h5A);
        chk("t6_rx_ferr", last_fe[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
